ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register that sits directly downstream of the ALU.
//  Latches the ALU Result, the store data and the memory/writeback controls each cycle.
//  Turns an ALU overflow on trap-enabled add/sub into a precise exception: it captures the EPC,
//  injects a bubble, flushes upstream for one cycle and keeps a sticky pending flag until acknowledged.
//  Drives the MEM-stage forwarding source back into EX.
// PARAMETERS
//  DW    32  datapath width (ALU Result, store data, PC)
//  RW    5   register-address width
//  CNTW  8   width of the saturating exception counters
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  reset           in   1     asynchronous, active-high reset
//  Stall           in   1     1 = hold every MEM-stage register
//  Flush           in   1     1 = load a bubble (ignored while Stall=1)
//  Valid_EX        in   1     EX-stage instruction is real (not a bubble)
//  ALUResult_EX    in   DW    ALU Result
//  Overflow_EX     in   1     ALU overflow flag
//  OvfEn_EX        in   1     instruction traps on overflow (signed add/sub)
//  MemWriteData_EX in   DW    store data (forwarded rt)
//  WriteReg_EX     in   RW    destination register number
//  RegWrite_EX     in   1     writeback enable
//  MemRead_EX      in   1     load
//  MemWrite_EX     in   1     store
//  MemtoReg_EX     in   1     writeback source select is memory
//  PC_EX           in   DW    PC of the EX-stage instruction
//  ExcAck          in   1     exception handler acknowledge; clears ExcPending
//  ALUResult_MEM   out  DW    registered ALU Result (memory address or writeback value)
//  MemWriteData_MEM out DW    registered store data
//  WriteReg_MEM    out  RW    registered destination register
//  RegWrite_MEM, MemRead_MEM, MemWrite_MEM, MemtoReg_MEM  out 1 each  registered controls
//  Valid_MEM       out  1     MEM-stage slot holds a real instruction
//  FwdEn_MEM       out  1     comb: RegWrite_MEM & (WriteReg_MEM!=0) & ~MemtoReg_MEM
//  ExcFlush        out  1     registered one-cycle pulse: flush IF/ID/EX
//  ExcPending      out  1     sticky exception flag
//  EPC             out  DW    PC of the first unacknowledged overflow
//  ExcCount        out  CNTW  exceptions taken, saturates at all-ones
//  OvfDropped      out  CNTW  overflows raised while ExcPending=1, saturates
// BEHAVIOUR
//  - reset (async): every output register = 0, asynchronously. FwdEn_MEM therefore = 0.
//  - Latency: 1 cycle EX->MEM. Per-edge priority: reset > Stall > Flush > ~Valid_EX > overflow trap > normal.
//  - Stall=1: all registers hold. ExcFlush=0. No exception is evaluated; it is evaluated on the edge where the stage advances.
//  - Flush=1 or Valid_EX=0 (no stall): bubble loaded.
//    - Valid_MEM and all four controls = 0.
//    - Data/WriteReg = 0.
//  - Trap: Valid_EX & OvfEn_EX & Overflow_EX, with ExcPending=0 or ExcAck=1.
//    - bubble loaded as above; ExcFlush=1 for exactly the next cycle.
//    - EPC <= PC_EX; ExcPending <= 1; ExcCount += 1 (saturating).
//  - Overflow while ExcPending=1 and ExcAck=0:
//    - bubble loaded; ExcFlush=1.
//    - EPC held; OvfDropped += 1 (saturating).
//  - Overflow with OvfEn_EX=0 (unsigned/logical ops): ignored; instruction latched normally.
//  - Normal: every *_EX field is copied to its *_MEM field and Valid_MEM=1.
//    - RegWrite_MEM is forced to 0 when WriteReg_EX==0, so $zero is never written.
//  - ExcAck=1 with no trap on that edge: ExcPending <= 0. EPC holds its value.
//  - ExcAck=1 together with a trap on the same edge: the new trap wins (EPC updated, ExcPending stays 1).
//  - ExcFlush is 0 on any edge that does not take an overflow, including Stall edges.
//  - Counters do not wrap; they are cleared only by reset.
//  - reset asserted mid-operation: pending exception, EPC and counters are all lost (cleared to 0).
// TESTING
//  1. Normal latch: ALUResult_EX=0x1234_5678, WriteReg_EX=8, RegWrite_EX=1, Valid_EX=1
//     -> next edge ALUResult_MEM=0x1234_5678, RegWrite_MEM=1, FwdEn_MEM=1.
//  2. Stall held 3 cycles while the EX inputs change -> MEM outputs unchanged.
//     Flush=1 together with Stall=1 -> still held. Flush=1 alone -> Valid_MEM=0, controls 0.
//  3. Trap: PC_EX=0x0040_0010, OvfEn_EX=1, Overflow_EX=1
//     -> EPC=0x0040_0010, ExcPending=1, ExcCount=1, ExcFlush high exactly 1 cycle, RegWrite_MEM=0.
//  4. Second overflow at PC 0x0040_0020 before ExcAck -> EPC stays 0x0040_0010, OvfDropped=1.
//     ExcAck and a third overflow (PC 0x0040_0030) on the same edge -> EPC=0x0040_0030, ExcPending=1, ExcCount=2.
//  5. Overflow_EX=1 with OvfEn_EX=0 -> normal latch, ExcPending unchanged.
//     WriteReg_EX=0 with RegWrite_EX=1 -> RegWrite_MEM=0.
//  6. reset pulsed between clock edges while ExcPending=1 and counters are nonzero
//     -> every output 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle.
// Carries the EX-side inputs of the EX/MEM pipeline register (datapath, controls,
// pipeline control, exception acknowledge) and everything the stage drives back
// (registered MEM fields, forwarding enable, exception outputs).
//   master : the surrounding pipeline (drives *_EX, Stall, Flush, ExcAck)
//   slave  : ex_mem_stage itself
interface ex_mem_stage_if #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 8
);
  // pipeline control
  logic            Stall;
  logic            Flush;
  logic            ExcAck;
  // EX-stage inputs
  logic            Valid_EX;
  logic [DW-1:0]   ALUResult_EX;
  logic            Overflow_EX;
  logic            OvfEn_EX;
  logic [DW-1:0]   MemWriteData_EX;
  logic [RW-1:0]   WriteReg_EX;
  logic            RegWrite_EX;
  logic            MemRead_EX;
  logic            MemWrite_EX;
  logic            MemtoReg_EX;
  logic [DW-1:0]   PC_EX;
  // MEM-stage outputs
  logic [DW-1:0]   ALUResult_MEM;
  logic [DW-1:0]   MemWriteData_MEM;
  logic [RW-1:0]   WriteReg_MEM;
  logic            RegWrite_MEM;
  logic            MemRead_MEM;
  logic            MemWrite_MEM;
  logic            MemtoReg_MEM;
  logic            Valid_MEM;
  logic            FwdEn_MEM;
  // exception outputs
  logic            ExcFlush;
  logic            ExcPending;
  logic [DW-1:0]   EPC;
  logic [CNTW-1:0] ExcCount;
  logic [CNTW-1:0] OvfDropped;

  modport master (
    output Stall, Flush, ExcAck, Valid_EX, ALUResult_EX, Overflow_EX, OvfEn_EX,
           MemWriteData_EX, WriteReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
           MemtoReg_EX, PC_EX,
    input  ALUResult_MEM, MemWriteData_MEM, WriteReg_MEM, RegWrite_MEM, MemRead_MEM,
           MemWrite_MEM, MemtoReg_MEM, Valid_MEM, FwdEn_MEM, ExcFlush, ExcPending,
           EPC, ExcCount, OvfDropped
  );

  modport slave (
    input  Stall, Flush, ExcAck, Valid_EX, ALUResult_EX, Overflow_EX, OvfEn_EX,
           MemWriteData_EX, WriteReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
           MemtoReg_EX, PC_EX,
    output ALUResult_MEM, MemWriteData_MEM, WriteReg_MEM, RegWrite_MEM, MemRead_MEM,
           MemWrite_MEM, MemtoReg_MEM, Valid_MEM, FwdEn_MEM, ExcFlush, ExcPending,
           EPC, ExcCount, OvfDropped
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register placed directly after the ALU.
// Latches ALU result, store data and MEM/WB controls with one cycle of latency,
// converts an overflow on a trapping add/sub into a precise exception (EPC capture,
// bubble, one-cycle upstream flush, sticky pending flag) and produces the MEM-stage
// forwarding enable.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : ex_mem_stage_if.slave (EX inputs, Stall/Flush/ExcAck, MEM and exception outputs)
module ex_mem_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 8
) (
  input  logic             clk,
  input  logic             reset,
  ex_mem_stage_if.slave    bus
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  logic [DW-1:0]   alu_result_p1;
  logic [DW-1:0]   store_data_p1;
  logic [RW-1:0]   write_reg_p1;
  logic            reg_write_p1;
  logic            mem_read_p1;
  logic            mem_write_p1;
  logic            mem_to_reg_p1;
  logic            vld_p1;
  logic            exc_flush_p1;
  logic            exc_pending;
  logic [DW-1:0]   epc;
  logic [CNTW-1:0] exc_count;
  logic [CNTW-1:0] ovf_dropped;

  logic ovf_hit;
  logic trap_take;
  logic bubble;

  // An overflow only matters on a real instruction that asked to trap.
  assign ovf_hit   = bus.Valid_EX & bus.OvfEn_EX & bus.Overflow_EX;
  // A new trap is accepted when nothing is pending or the handler acks on this edge.
  assign trap_take = ovf_hit & (~exc_pending | bus.ExcAck);
  assign bubble    = bus.Flush | ~bus.Valid_EX | ovf_hit;

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_p1 <= '0;
      store_data_p1 <= '0;
      write_reg_p1  <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      vld_p1        <= 1'b0;
      exc_flush_p1  <= 1'b0;
      exc_pending   <= 1'b0;
      epc           <= '0;
      exc_count     <= '0;
      ovf_dropped   <= '0;
    end else if (bus.Stall) begin
      // Everything holds; the flush pulse must not stretch across a stall.
      exc_flush_p1 <= 1'b0;
    end else begin
      exc_flush_p1 <= 1'b0;
      if (bubble) begin
        alu_result_p1 <= '0;
        store_data_p1 <= '0;
        write_reg_p1  <= '0;
        reg_write_p1  <= 1'b0;
        mem_read_p1   <= 1'b0;
        mem_write_p1  <= 1'b0;
        mem_to_reg_p1 <= 1'b0;
        vld_p1        <= 1'b0;
      end else begin
        alu_result_p1 <= bus.ALUResult_EX;
        store_data_p1 <= bus.MemWriteData_EX;
        write_reg_p1  <= bus.WriteReg_EX;
        reg_write_p1  <= bus.RegWrite_EX & (bus.WriteReg_EX != '0);
        mem_read_p1   <= bus.MemRead_EX;
        mem_write_p1  <= bus.MemWrite_EX;
        mem_to_reg_p1 <= bus.MemtoReg_EX;
        vld_p1        <= 1'b1;
      end

      // Flush has priority, so a flushed overflow never reaches the trap logic.
      if (!bus.Flush && ovf_hit) begin
        exc_flush_p1 <= 1'b1;
        if (trap_take) begin
          epc         <= bus.PC_EX;
          exc_pending <= 1'b1;
          exc_count   <= sat_inc(exc_count);
        end else begin
          ovf_dropped <= sat_inc(ovf_dropped);
        end
      end else if (bus.ExcAck) begin
        exc_pending <= 1'b0;
      end
    end
  end

  assign bus.ALUResult_MEM    = alu_result_p1;
  assign bus.MemWriteData_MEM = store_data_p1;
  assign bus.WriteReg_MEM     = write_reg_p1;
  assign bus.RegWrite_MEM     = reg_write_p1;
  assign bus.MemRead_MEM      = mem_read_p1;
  assign bus.MemWrite_MEM     = mem_write_p1;
  assign bus.MemtoReg_MEM     = mem_to_reg_p1;
  assign bus.Valid_MEM        = vld_p1;
  // Loads are not forwardable from MEM; their data is not ready yet.
  assign bus.FwdEn_MEM        = reg_write_p1 & (write_reg_p1 != '0) & ~mem_to_reg_p1;
  assign bus.ExcFlush         = exc_flush_p1;
  assign bus.ExcPending       = exc_pending;
  assign bus.EPC              = epc;
  assign bus.ExcCount         = exc_count;
  assign bus.OvfDropped       = ovf_dropped;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: latch, stall/flush, trap, dropped overflow,
// ack/trap collision, non-trapping overflow, $zero write suppression, async reset
// and counter saturation.
module tb_ex_mem_stage;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  ex_mem_stage_if #(.DW(32), .RW(5), .CNTW(8)) bus ();

  ex_mem_stage #(.DW(32), .RW(5), .CNTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                           input logic [31:0] pc, input logic oen, input logic ovf);
    bus.Valid_EX        = 1'b1;
    bus.ALUResult_EX    = alu;
    bus.WriteReg_EX     = rd;
    bus.RegWrite_EX     = rw;
    bus.PC_EX           = pc;
    bus.OvfEn_EX        = oen;
    bus.Overflow_EX     = ovf;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.ExcAck = 1'b0;
    bus.Valid_EX = 1'b0; bus.ALUResult_EX = '0; bus.Overflow_EX = 1'b0; bus.OvfEn_EX = 1'b0;
    bus.MemWriteData_EX = '0; bus.WriteReg_EX = '0; bus.RegWrite_EX = 1'b0;
    bus.MemRead_EX = 1'b0; bus.MemWrite_EX = 1'b0; bus.MemtoReg_EX = 1'b0; bus.PC_EX = '0;
    #2;
    check("rst_alu", bus.ALUResult_MEM, 0);
    check("rst_valid", bus.Valid_MEM, 0);
    check("rst_fwd", bus.FwdEn_MEM, 0);
    check("rst_pend", bus.ExcPending, 0);
    #1 reset = 1'b0;   // released between edges

    // 1. normal latch
    set_instr(32'h1234_5678, 5'd8, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
    bus.MemWriteData_EX = 32'h0000_AABB;
    step();
    check("n_alu", bus.ALUResult_MEM, 32'h1234_5678);
    check("n_sd", bus.MemWriteData_MEM, 32'h0000_AABB);
    check("n_wr", bus.WriteReg_MEM, 8);
    check("n_rw", bus.RegWrite_MEM, 1);
    check("n_fwd", bus.FwdEn_MEM, 1);
    check("n_valid", bus.Valid_MEM, 1);

    // 2. stall holds while inputs change
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(32'hDEAD_0000 + i, 5'd9, 1'b0, 32'h0040_0004, 1'b0, 1'b0);
      step();
      check("st_alu", bus.ALUResult_MEM, 32'h1234_5678);
      check("st_wr", bus.WriteReg_MEM, 8);
    end
    bus.Flush = 1'b1;
    step();
    check("stf_valid", bus.Valid_MEM, 1);
    check("stf_alu", bus.ALUResult_MEM, 32'h1234_5678);
    bus.Stall = 1'b0;
    step();
    check("fl_valid", bus.Valid_MEM, 0);
    check("fl_rw", bus.RegWrite_MEM, 0);
    check("fl_alu", bus.ALUResult_MEM, 0);
    check("fl_fwd", bus.FwdEn_MEM, 0);
    bus.Flush = 1'b0;

    // 3. trap
    set_instr(32'h0000_0011, 5'd3, 1'b1, 32'h0040_0010, 1'b1, 1'b1);
    step();
    check("tr_epc", bus.EPC, 32'h0040_0010);
    check("tr_pend", bus.ExcPending, 1);
    check("tr_cnt", bus.ExcCount, 1);
    check("tr_flush", bus.ExcFlush, 1);
    check("tr_rw", bus.RegWrite_MEM, 0);
    check("tr_valid", bus.Valid_MEM, 0);
    set_instr(32'h0000_0022, 5'd3, 1'b1, 32'h0040_0014, 1'b1, 1'b0);
    step();
    check("tr_flush_off", bus.ExcFlush, 0);
    check("tr_pend_hold", bus.ExcPending, 1);
    check("tr_valid2", bus.Valid_MEM, 1);

    // 4. dropped overflow, then ack + new trap on the same edge
    set_instr(32'h0000_0033, 5'd3, 1'b1, 32'h0040_0020, 1'b1, 1'b1);
    step();
    check("dr_epc", bus.EPC, 32'h0040_0010);
    check("dr_drop", bus.OvfDropped, 1);
    check("dr_flush", bus.ExcFlush, 1);
    check("dr_cnt", bus.ExcCount, 1);
    set_instr(32'h0000_0044, 5'd3, 1'b1, 32'h0040_0030, 1'b1, 1'b1);
    bus.ExcAck = 1'b1;
    step();
    check("ak_epc", bus.EPC, 32'h0040_0030);
    check("ak_pend", bus.ExcPending, 1);
    check("ak_cnt", bus.ExcCount, 2);
    check("ak_drop", bus.OvfDropped, 1);
    bus.ExcAck = 1'b0;

    // 5. non-trapping overflow, $zero suppression, load controls
    set_instr(32'h0000_0055, 5'd4, 1'b1, 32'h0040_0034, 1'b0, 1'b1);
    step();
    check("nt_valid", bus.Valid_MEM, 1);
    check("nt_alu", bus.ALUResult_MEM, 32'h55);
    check("nt_pend", bus.ExcPending, 1);
    check("nt_flush", bus.ExcFlush, 0);
    set_instr(32'h0000_0066, 5'd0, 1'b1, 32'h0040_0038, 1'b0, 1'b0);
    step();
    check("z_rw", bus.RegWrite_MEM, 0);
    check("z_fwd", bus.FwdEn_MEM, 0);
    check("z_valid", bus.Valid_MEM, 1);
    set_instr(32'h0000_0077, 5'd5, 1'b1, 32'h0040_003C, 1'b0, 1'b0);
    bus.MemRead_EX = 1'b1; bus.MemtoReg_EX = 1'b1;
    step();
    check("ld_mr", bus.MemRead_MEM, 1);
    check("ld_m2r", bus.MemtoReg_MEM, 1);
    check("ld_fwd", bus.FwdEn_MEM, 0);
    bus.MemRead_EX = 1'b0; bus.MemtoReg_EX = 1'b0;

    // ack with no trap clears pending, EPC holds
    bus.ExcAck = 1'b1;
    step();
    check("ack_pend", bus.ExcPending, 0);
    check("ack_epc", bus.EPC, 32'h0040_0030);
    bus.ExcAck = 1'b0;

    // overflow during stall is not evaluated
    bus.Stall = 1'b1;
    set_instr(32'h0000_0088, 5'd6, 1'b1, 32'h0040_0040, 1'b1, 1'b1);
    step();
    check("sto_flush", bus.ExcFlush, 0);
    check("sto_cnt", bus.ExcCount, 2);
    bus.Stall = 1'b0;
    step();
    check("sto_take", bus.ExcCount, 3);
    check("sto_epc", bus.EPC, 32'h0040_0040);
    check("sto_pend", bus.ExcPending, 1);

    // 6. asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    check("ar_pend", bus.ExcPending, 0);
    check("ar_epc", bus.EPC, 0);
    check("ar_cnt", bus.ExcCount, 0);
    check("ar_drop", bus.OvfDropped, 0);
    check("ar_valid", bus.Valid_MEM, 0);
    check("ar_alu", bus.ALUResult_MEM, 0);
    check("ar_wr", bus.WriteReg_MEM, 0);
    check("ar_fwd", bus.FwdEn_MEM, 0);
    #1 reset = 1'b0;

    // counter saturation
    bus.ExcAck = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_instr(32'h0, 5'd1, 1'b1, 32'h1000_0000 + i, 1'b1, 1'b1);
      step();
    end
    check("sat_cnt", bus.ExcCount, 8'hFF);
    check("sat_epc", bus.EPC, 32'h1000_0103);
    bus.ExcAck = 1'b0;
    for (int i = 0; i < 260; i++) begin
      set_instr(32'h0, 5'd1, 1'b1, 32'h2000_0000 + i, 1'b1, 1'b1);
      step();
    end
    check("sat_drop", bus.OvfDropped, 8'hFF);
    check("sat_cnt2", bus.ExcCount, 8'hFF);
    check("sat_epc2", bus.EPC, 32'h1000_0103);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
